divider_seq: RTL and testbench
==============================

# divider_seq

Sequential radix-2 restoring divider: the inverse of the datapath's 8x8 unsigned multiplier. It accepts a 2W-bit unsigned dividend and a W-bit unsigned divisor through a valid/ready handshake. It iterates one quotient bit per clock and returns a W-bit quotient and a W-bit remainder, with divide-by-zero and quotient-overflow flags. It sits next to the vector multiplier lanes as the divide/recover unit, for example to check a product by dividing it back by one operand.

## Interface
- `DIV_WIDTH`, default 8: operand width W. Dividend is 2W bits; quotient and remainder are W bits.
- `clk` in, 1: single clock; everything is rising-edge.
- `rst` in, 1: synchronous, active-high reset.
- `in_valid` in, 1: request valid.
- `in_ready` out, 1: block can accept a request.
- `dividend` in, 2W: unsigned dividend.
- `divisor` in, W: unsigned divisor.
- `out_valid` out, 1: result valid.
- `out_ready` in, 1: consumer accepts the result.
- `quotient` out, W: unsigned quotient.
- `remainder` out, W: unsigned remainder.
- `err_div_zero` out, 1: divisor was 0.
- `err_overflow` out, 1: quotient does not fit in W bits.

## Operation
- FSM states:
  - IDLE: `in_ready`=1.
  - CALC: W iterations, counter `step` runs 0..W-1.
  - DONE: `out_valid`=1.
- IDLE transitions, on accept (`in_valid` & `in_ready`):
  - Capture `R`=`dividend[2W-1:W]`, `Q`=`dividend[W-1:0]`, `D`=`divisor`.
  - If `divisor`==0: set `err_div_zero`=1, `quotient`=all-ones, `remainder`=all-ones, go to DONE.
  - Else if `dividend[2W-1:W]` >= `divisor`: set `err_overflow`=1, same all-ones result, go to DONE.
  - Else go to CALC with `step`=0.
- CALC, each cycle:
  - `T`={`R`,`Q[W-1]`} (W+1 bits).
  - If `T` >= {1'b0,`D`}: `R`=`T`-`D` truncated to W bits, and the quotient bit is 1.
  - Else: `R`=`T[W-1:0]`, and the quotient bit is 0.
  - `Q`={`Q[W-2:0]`, quotient bit}.
  - When `step`==W-1: load `quotient`=`Q`, `remainder`=`R`, go to DONE.
- DONE: hold all result outputs stable while `out_valid` & !`out_ready`. On `out_ready`=1, go to IDLE and drop `out_valid`.
- Inputs are sampled only on accept; input changes during CALC/DONE are ignored.
- `in_ready` is low in CALC and DONE. There is no input buffering and no overlap between operations.
- Reset values: `in_ready`=0 while `rst` is high and 1 from the first cycle after; `out_valid`=0, `quotient`=0, `remainder`=0, `err_div_zero`=0, `err_overflow`=0; state is IDLE.
- A reset asserted in any state, including mid-CALC or DONE, discards the in-flight operation and applies the reset values on that edge.
- Error flags are cleared on every accept.

## Timing
- Normal operation: accept at edge E0, CALC on edges E1..EW, `out_valid` high after edge EW. For W=8 that is 8 cycles from accept to result.
- Error operation: `out_valid` high after E0, a 1-cycle latency.
- Result is consumed on the edge where `out_valid` & `out_ready`. `in_ready` is high the following cycle.
- Minimum issue interval is W+2 cycles when `out_ready` is held high.
- The comparison and subtraction are single-cycle combinational, W+1 bits wide. There is no multicycle path.

## Configuration
- `DIVIDER_SEQ_ERR_CHECK_EN` defined:
  - Zero and overflow detection is present as described above.
- Not defined:
  - No detection logic; `err_div_zero` and `err_overflow` are tied to 0.
  - Every accept enters CALC and the result is whatever W iterations produce.
  - Divisor 0 yields `quotient`=all-ones and `remainder`=`dividend[W-1:0]`-derived truncation. The bench checks only the flags for this case.
  - Latency is always W cycles.

## Structure
- Package `divider_pkg`: state enum (IDLE, CALC, DONE) and a function computing the `step` counter width from `DIV_WIDTH`.
- Sub-module `div_restore_step`: combinational, (W+1)-bit compare/subtract. Inputs `T` and `D`; outputs next `R` and the quotient bit. Instantiated once and reused every iteration.
- The top level holds the FSM, the `R`/`Q`/`D` registers, the counter and the handshake logic.

## Test plan
- 16'd1000 / 8'd7: `quotient`=8'd142, `remainder`=8'd6, no error flags, `out_valid` exactly 8 cycles after accept.
- 16'hFE01 / 8'hFF (the multiplier's maximum product): `quotient`=8'hFF, `remainder`=8'h00; also sweep 1000 random product/operand pairs and require a zero remainder every time.
- With the macro defined, 16'h1234 / 8'h00: `err_div_zero`=1, `quotient`=8'hFF, `remainder`=8'hFF, `out_valid` 1 cycle after accept. Then 16'h0A00 / 8'h05: `err_overflow`=1, with `err_div_zero` cleared.
- 16'd500 / 8'd9 with `out_ready` held low 5 cycles after `out_valid`: `quotient`=55 and `remainder`=5 stay stable and `in_ready`=0 throughout. After release, `in_ready`=1 the next cycle.
- Assert `rst` for one cycle at CALC step 4: all outputs are 0 the next cycle and `in_ready`=1 after. A following 16'd255 / 8'd16 yields 15 r 15.
- Toggle `dividend`/`divisor` every cycle during CALC: the result matches the values captured at accept.

Source files
------------

// File: rtl/divider_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } div_state_t;

  // Width of a counter that has to reach w-1 (never narrower than one bit).
  function automatic int step_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division iteration: compare the (W+1)-bit partial remainder
// against the divisor and subtract when it fits.
module div_restore_step #(
  parameter int W = 8
) (
  input  logic [W:0]   t,
  input  logic [W-1:0] d,
  output logic [W-1:0] r_next,
  output logic         q_bit
);

  logic [W:0] diff;

  assign diff   = t - {1'b0, d};
  assign q_bit  = (t >= {1'b0, d});
  assign r_next = q_bit ? diff[W-1:0] : t[W-1:0];

endmodule

// File: rtl/divider_seq.sv
// divider_seq: radix-2 restoring divider, 2W-bit / W-bit -> W-bit quotient and remainder.
// Define DIVIDER_SEQ_ERR_CHECK_EN to enable divide-by-zero and quotient-overflow detection.
module divider_seq
  import divider_pkg::*;
#(
  parameter int DIV_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2*DIV_WIDTH-1:0] dividend,
  input  logic [DIV_WIDTH-1:0]   divisor,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DIV_WIDTH-1:0]   quotient,
  output logic [DIV_WIDTH-1:0]   remainder,
  output logic                   err_div_zero,
  output logic                   err_overflow
);

  localparam int W  = DIV_WIDTH;
  localparam int SW = step_width(W);
  localparam logic [SW-1:0] LAST_STEP = SW'(W - 1);

  div_state_t state, state_next;

  logic [W-1:0]  r_reg, q_reg, d_reg;
  logic [SW-1:0] step;
  logic [W-1:0]  r_next, q_next;
  logic          q_bit;
  logic          accept, last_step, err_zero, err_ovf;

  assign accept    = in_valid && in_ready;
  assign last_step = (step == LAST_STEP);
  assign q_next    = (q_reg << 1) | W'(q_bit);

`ifdef DIVIDER_SEQ_ERR_CHECK_EN
  assign err_zero = (divisor == '0);
  assign err_ovf  = (dividend[2*W-1:W] >= divisor);
`else
  assign err_zero = 1'b0;
  assign err_ovf  = 1'b0;
`endif

  div_restore_step #(.W(W)) u_step (
    .t      ({r_reg, q_reg[W-1]}),
    .d      (d_reg),
    .r_next (r_next),
    .q_bit  (q_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = (err_zero || err_ovf) ? DONE : CALC;
      CALC: if (last_step) state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // in_ready is gated by rst so nothing is accepted on a reset edge.
  always_comb begin
    in_ready  = (state == IDLE) && !rst;
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_reg        <= '0;
      q_reg        <= '0;
      d_reg        <= '0;
      step         <= '0;
      quotient     <= '0;
      remainder    <= '0;
      err_div_zero <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          r_reg        <= dividend[2*W-1:W];
          q_reg        <= dividend[W-1:0];
          d_reg        <= divisor;
          step         <= '0;
          err_div_zero <= err_zero;
          err_overflow <= err_ovf && !err_zero;
          if (err_zero || err_ovf) begin
            quotient  <= '1;
            remainder <= '1;
          end
        end
        CALC: begin
          r_reg <= r_next;
          q_reg <= q_next;
          step  <= step + 1'b1;
          if (last_step) begin
            quotient  <= q_next;
            remainder <= r_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_seq.sv
// Self-checking bench for divider_seq: directed vector table, handshake and reset
// corner sequences, and randomized operands against plain-arithmetic division.
module tb_divider_seq;

  localparam int W = 8;
`ifdef DIVIDER_SEQ_ERR_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [2*W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         err_div_zero;
  logic         err_overflow;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [15:0] dvd;
    logic [7:0]  dvs;
    logic [7:0]  q;
    logic [7:0]  r;
    bit          dz;
    bit          ov;
    int          lat;
    bit          chk;
    string       name;
  } vec_t;

  vec_t vecs[$];

  divider_seq #(.DIV_WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .dividend     (dividend),
    .divisor      (divisor),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .quotient     (quotient),
    .remainder    (remainder),
    .err_div_zero (err_div_zero),
    .err_overflow (err_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Waits for in_ready, issues one request, returns edges after the accept
  // edge until out_valid is seen (capped at 50).
  task automatic applyStimulus(input logic [15:0] dvd, input logic [7:0] dvs, output int lat);
    int guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    check("in_ready before issue", {31'd0, in_ready}, 32'd1);
    dividend = dvd;
    divisor  = dvs;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic checkOutput(input string name, input logic [7:0] eq, input logic [7:0] er,
                             input bit edz, input bit eov, input bit chk_res);
    check($sformatf("%s out_valid", name), {31'd0, out_valid}, 32'd1);
    check($sformatf("%s err_div_zero", name), {31'd0, err_div_zero}, {31'd0, edz});
    check($sformatf("%s err_overflow", name), {31'd0, err_overflow}, {31'd0, eov});
    check($sformatf("%s in_ready in DONE", name), {31'd0, in_ready}, 32'd0);
    if (chk_res) begin
      check($sformatf("%s quotient", name), {24'd0, quotient}, {24'd0, eq});
      check($sformatf("%s remainder", name), {24'd0, remainder}, {24'd0, er});
    end
  endtask

  task automatic consumeResult(input string name);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check($sformatf("%s out_valid dropped", name), {31'd0, out_valid}, 32'd0);
    check($sformatf("%s in_ready after consume", name), {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    int lat;
    logic [15:0] dvd;
    logic [7:0]  dvs, a, b, hi;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;

    vecs.push_back('{16'd1000,  8'd7,   8'd142, 8'd6,   1'b0,   1'b0,   8, 1'b1, "1000/7"});
    vecs.push_back('{16'hFE01,  8'hFF,  8'hFF,  8'h00,  1'b0,   1'b0,   8, 1'b1, "FE01/FF"});
    vecs.push_back('{16'h1234,  8'h00,  8'hFF,  8'hFF,  ERR_EN, 1'b0,   ERR_EN ? 0 : 8, ERR_EN, "div zero"});
    vecs.push_back('{16'h0A00,  8'h05,  8'hFF,  8'hFF,  1'b0,   ERR_EN, ERR_EN ? 0 : 8, ERR_EN, "overflow"});
    vecs.push_back('{16'd0,     8'd1,   8'd0,   8'd0,   1'b0,   1'b0,   8, 1'b1, "0/1"});
    vecs.push_back('{16'h00FF,  8'h01,  8'hFF,  8'h00,  1'b0,   1'b0,   8, 1'b1, "00FF/01"});
    vecs.push_back('{16'h7FFF,  8'h80,  8'hFF,  8'h7F,  1'b0,   1'b0,   8, 1'b1, "7FFF/80"});
    vecs.push_back('{16'd255,   8'd16,  8'd15,  8'd15,  1'b0,   1'b0,   8, 1'b1, "255/16"});

    // Reset state
    @(posedge clk); @(posedge clk); #1;
    check("reset in_ready", {31'd0, in_ready}, 32'd0);
    check("reset out_valid", {31'd0, out_valid}, 32'd0);
    check("reset quotient", {24'd0, quotient}, 32'd0);
    check("reset remainder", {24'd0, remainder}, 32'd0);
    check("reset err_div_zero", {31'd0, err_div_zero}, 32'd0);
    check("reset err_overflow", {31'd0, err_overflow}, 32'd0);
    rst = 1'b0;
    #1;
    check("in_ready after reset", {31'd0, in_ready}, 32'd1);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].dvd, vecs[i].dvs, lat);
      check($sformatf("%s latency", vecs[i].name), lat, vecs[i].lat);
      checkOutput(vecs[i].name, vecs[i].q, vecs[i].r, vecs[i].dz, vecs[i].ov, vecs[i].chk);
      consumeResult(vecs[i].name);
    end

    // Back-pressure: result must hold while out_ready stays low
    applyStimulus(16'd500, 8'd9, lat);
    check("hold latency", lat, 8);
    for (int c = 0; c < 5; c++) begin
      checkOutput($sformatf("hold cycle %0d", c), 8'd55, 8'd5, 1'b0, 1'b0, 1'b1);
      @(posedge clk); #1;
    end
    checkOutput("hold release", 8'd55, 8'd5, 1'b0, 1'b0, 1'b1);
    consumeResult("hold");

    // Reset pulse with step==4 in flight
    dividend = 16'd1000;
    divisor  = 8'd7;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    check("mid-calc out_valid", {31'd0, out_valid}, 32'd0);
    rst = 1'b1;
    #1;
    check("in_ready during rst", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("mid rst out_valid", {31'd0, out_valid}, 32'd0);
    check("mid rst quotient", {24'd0, quotient}, 32'd0);
    check("mid rst remainder", {24'd0, remainder}, 32'd0);
    check("mid rst err flags", {30'd0, err_div_zero, err_overflow}, 32'd0);
    check("mid rst in_ready", {31'd0, in_ready}, 32'd1);
    applyStimulus(16'd255, 8'd16, lat);
    check("post rst latency", lat, 8);
    checkOutput("post rst 255/16", 8'd15, 8'd15, 1'b0, 1'b0, 1'b1);
    consumeResult("post rst");

    // Inputs toggling during CALC must be ignored
    dividend = 16'd1000;
    divisor  = 8'd7;
    in_valid = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    while (!out_valid && lat < 50) begin
      dividend = 16'($urandom);
      divisor  = 8'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    check("toggle latency", lat, 8);
    checkOutput("toggle", 8'd142, 8'd6, 1'b0, 1'b0, 1'b1);
    consumeResult("toggle");

    // Divide random products back by one operand
    for (int n = 0; n < 1000; n++) begin
      a   = 8'($urandom_range(1, 255));
      b   = 8'($urandom_range(0, 255));
      dvd = 16'(a) * 16'(b);
      applyStimulus(dvd, a, lat);
      check($sformatf("prod %0d/%0d quotient", dvd, a), {24'd0, quotient}, {24'd0, b});
      check($sformatf("prod %0d/%0d remainder", dvd, a), {24'd0, remainder}, 32'd0);
      consumeResult("prod");
    end

    // Random in-range divisions against plain arithmetic
    for (int n = 0; n < 200; n++) begin
      dvs = 8'($urandom_range(1, 255));
      hi  = 8'($urandom_range(0, int'(dvs) - 1));
      dvd = {hi, 8'($urandom)};
      applyStimulus(dvd, dvs, lat);
      check($sformatf("rand %0d/%0d latency", dvd, dvs), lat, 8);
      checkOutput($sformatf("rand %0d/%0d", dvd, dvs), 8'(dvd / 16'(dvs)), 8'(dvd % 16'(dvs)),
                  1'b0, 1'b0, 1'b1);
      consumeResult("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
